button_event_ctrl: RTL and testbench

//  Sequences N debounced button levels (one debounce instance per button) into a single

---
 rtl/button_event_ctrl_if.sv | 21 ++
 rtl/button_event_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_if.sv
// Event stream between the button sequencer (master) and its consumer (slave).
interface button_event_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_btn;
  logic [1:0]       evt_type;
  logic             evt_ovf;
  logic             ovf_clr;

  modport master (
    output evt_valid, evt_btn, evt_type, evt_ovf,
    input  evt_ready, ovf_clr
  );

  modport slave (
    input  evt_valid, evt_btn, evt_type, evt_ovf,
    output evt_ready, ovf_clr
  );
endinterface

// File: rtl/button_event_ctrl.sv
// Turns N debounced button levels into a single press/release/long/repeat event
// stream: per-button FSMs feed one-deep pending slots drained by a round-robin arbiter.
module button_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_clean,
  button_event_ctrl_if.master evt
);
  localparam int IDX_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int MAX_T   = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(MAX_T + 1);
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} state_e;
  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } evt_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;
  logic [N_BTN-1:0]   prev_q, rise, fall;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [CNT_W-1:0] cnt_inc [N_BTN];
  logic [N_BTN-1:0] thr;
  logic [N_BTN-1:0] raise;
  evt_e             rtype   [N_BTN];

  logic [N_BTN-1:0] pend_q, pend_d, drop, grant;
  evt_e             ptype_q [N_BTN];
  evt_e             ptype_d [N_BTN];

  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] btn_q, btn_d, ptr_q, ptr_d, gidx;
  evt_e             type_q, type_d;
  logic             load_en, found;
  int unsigned      scan;

  always_comb begin
    tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  assign rise = btn_clean & ~prev_q;
  assign fall = ~btn_clean & prev_q;

  // Tick threshold is shared by PRESSED (towards LONG) and HELD (towards REPEAT).
  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cnt_inc[i] = cnt_q[i] + CNT_W'(1);
      thr[i]     = tick && (cnt_inc[i] == ((state_q[i] == ST_HELD) ? REPEAT_C : LONG_C));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end
        end
        ST_PRESSED, ST_HELD: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end else if (thr[i]) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
          end else if (tick) begin
            cnt_d[i] = cnt_inc[i];
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      raise[i] = 1'b0;
      rtype[i] = EV_PRESS;
      case (state_q[i])
        ST_IDLE: raise[i] = rise[i];
        ST_PRESSED: begin
          if (fall[i]) begin
            raise[i] = 1'b1;
            rtype[i] = EV_RELEASE;
          end else if (thr[i]) begin
            raise[i] = 1'b1;
            rtype[i] = EV_LONG;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            raise[i] = 1'b1;
            rtype[i] = EV_RELEASE;
          end else if (thr[i]) begin
            raise[i] = 1'b1;
            rtype[i] = EV_REPEAT;
          end
        end
        default: raise[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    load_en = !valid_q || evt.evt_ready;
    found   = 1'b0;
    gidx    = '0;
    scan    = 0;
    grant   = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= N_BTN) scan = scan - N_BTN;
      if (!found && pend_q[IDX_W'(scan)]) begin
        found = 1'b1;
        gidx  = IDX_W'(scan);
      end
    end
    if (load_en && found) grant[gidx] = 1'b1;
  end

  // A slot granted this cycle is free again, so a same-cycle raise reloads it.
  always_comb begin
    drop = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      pend_d[i]  = pend_q[i] & ~grant[i];
      ptype_d[i] = ptype_q[i];
      if (raise[i]) begin
        if (pend_d[i]) begin
          drop[i] = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = rtype[i];
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    btn_d   = btn_q;
    type_d  = type_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = found;
      if (found) begin
        btn_d  = gidx;
        type_d = ptype_q[gidx];
        ptr_d  = (gidx == IDX_W'(N_BTN - 1)) ? '0 : gidx + IDX_W'(1);
      end
    end
    ovf_d = (|drop) | (ovf_q & ~evt.ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) ptype_q[i] <= EV_PRESS;
      valid_q <= 1'b0;
      btn_q   <= '0;
      type_q  <= EV_PRESS;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      prev_q  <= btn_clean;
      pend_q  <= pend_d;
      for (int unsigned i = 0; i < N_BTN; i++) ptype_q[i] <= ptype_d[i];
      valid_q <= valid_d;
      btn_q   <= btn_d;
      type_q  <= type_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_btn   = btn_q;
  assign evt.evt_type  = type_q;
  assign evt.evt_ovf   = ovf_q;
endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: vector table, directed corner sequences
// and randomized traffic against an event-level reference model.
module tb_button_event_ctrl;
  localparam int N_BTN        = 4;
  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 3;
  localparam int REPEAT_TICKS = 2;
  localparam int IDX_W        = 2;
  localparam logic [1:0] T_PRESS = 2'd0, T_REL = 2'd1, T_LONG = 2'd2, T_REP = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_BTN-1:0] btn = '0;

  button_event_ctrl_if #(.IDX_W(IDX_W)) evt_if ();

  button_event_ctrl #(
    .N_BTN(N_BTN), .TICK_DIV(TICK_DIV),
    .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .btn_clean(btn), .evt(evt_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = -1;
  bit model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: event level, tick counted since press
  bit         m_prev [N_BTN];
  bit         m_down [N_BTN];
  int         m_ticks[N_BTN];
  bit         m_pend [N_BTN];
  logic [1:0] m_ptype[N_BTN];
  bit         m_valid, m_ovf;
  int         m_btn, m_ptr, m_cyc;
  logic [1:0] m_type;

  function automatic void model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      m_prev[i] = 0; m_down[i] = 0; m_ticks[i] = 0; m_pend[i] = 0; m_ptype[i] = T_PRESS;
    end
    m_valid = 0; m_ovf = 0; m_btn = 0; m_ptr = 0; m_cyc = 0; m_type = T_PRESS;
  endfunction

  function automatic void model_step();
    bit         tk, b, set_ovf;
    bit         rz [N_BTN];
    logic [1:0] rt [N_BTN];
    int         g, j;
    tk = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
    set_ovf = 0;
    for (int i = 0; i < N_BTN; i++) begin
      b = ((btn >> i) & 1) != 0;
      rz[i] = 0; rt[i] = T_PRESS;
      if (b && !m_prev[i]) begin
        rz[i] = 1; rt[i] = T_PRESS; m_down[i] = 1; m_ticks[i] = 0;
      end else if (!b && m_prev[i]) begin
        rz[i] = 1; rt[i] = T_REL; m_down[i] = 0;
      end else if (m_down[i] && tk) begin
        m_ticks[i]++;
        if (m_ticks[i] == LONG_TICKS) begin
          rz[i] = 1; rt[i] = T_LONG;
        end else if (m_ticks[i] > LONG_TICKS && ((m_ticks[i] - LONG_TICKS) % REPEAT_TICKS) == 0) begin
          rz[i] = 1; rt[i] = T_REP;
        end
      end
      m_prev[i] = b;
    end
    if (!m_valid || evt_if.evt_ready) begin
      g = -1;
      for (int k = 0; k < N_BTN; k++) begin
        j = (m_ptr + k) % N_BTN;
        if (g < 0 && m_pend[j]) g = j;
      end
      if (g >= 0) begin
        m_valid = 1; m_btn = g; m_type = m_ptype[g]; m_pend[g] = 0; m_ptr = (g + 1) % N_BTN;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (rz[i]) begin
        if (m_pend[i]) set_ovf = 1;
        else begin m_pend[i] = 1; m_ptype[i] = rt[i]; end
      end
    end
    m_ovf = set_ovf || (m_ovf && !evt_if.ovf_clr);
    m_cyc++;
  endfunction

  // ---------------- clocking helpers
  task automatic tick_clk();
    @(posedge clk);
    if (model_on) model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst valid", evt_if.evt_valid, 0);
    check("rst btn",   evt_if.evt_btn,   0);
    check("rst type",  evt_if.evt_type,  0);
    check("rst ovf",   evt_if.evt_ovf,   0);
    rst = 1'b0;
    cyc = -1;
    model_reset();
  endtask

  task automatic expect_out(input string name, input bit v, input logic [1:0] b,
                            input logic [1:0] t, input bit o);
    check({name, " valid"}, evt_if.evt_valid, v);
    if (v) begin
      check({name, " btn"},  evt_if.evt_btn,  b);
      check({name, " type"}, evt_if.evt_type, t);
    end
    check({name, " ovf"}, evt_if.evt_ovf, o);
  endtask

  // ---------------- event collection for multi-cycle sequences
  int         ac[$];
  logic [1:0] at[$];
  logic [1:0] ab[$];
  int         xc[$];
  logic [1:0] xt[$];

  task automatic collect();
    if (evt_if.evt_valid === 1'b1) begin
      ac.push_back(cyc); at.push_back(evt_if.evt_type); ab.push_back(evt_if.evt_btn);
    end
  endtask

  task automatic cmp_events(input string name, input logic [1:0] eb);
    check({name, " count"}, ac.size(), xc.size());
    for (int k = 0; k < xc.size() && k < ac.size(); k++) begin
      check($sformatf("%s ev%0d cycle", name, k), ac[k], xc[k]);
      check($sformatf("%s ev%0d type", name, k), at[k], xt[k]);
      check($sformatf("%s ev%0d btn", name, k), ab[k], eb);
    end
    ac.delete(); at.delete(); ab.delete(); xc.delete(); xt.delete();
  endtask

  // ---------------- vector table
  typedef struct {
    bit               rst;
    logic [N_BTN-1:0] btn;
    bit               ev;
    logic [1:0]       eb;
    logic [1:0]       et;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit r, input logic [N_BTN-1:0] b, input bit ev,
                              input logic [1:0] eb, input logic [1:0] et);
    vec_t v;
    v.rst = r; v.btn = b; v.ev = ev; v.eb = eb; v.et = et;
    tbl.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_BTN-1:0] mask;
    evt_if.evt_ready = 1'b1;
    evt_if.ovf_clr   = 1'b0;

    // press/hold/release of btn0, then simultaneous presses with pointer 0 and 2
    add(1, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 0);
    add(0, 4'b0001, 1, 0, T_PRESS);
    add(0, 4'b0001, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 0, T_REL);
    add(0, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 0, 0);
    add(0, 4'b1111, 1, 0, T_PRESS);
    add(0, 4'b1111, 1, 1, T_PRESS);
    add(0, 4'b1111, 1, 2, T_PRESS);
    add(0, 4'b1111, 1, 3, T_PRESS);
    add(0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 0, T_REL);
    add(0, 4'b0000, 1, 1, T_REL);
    add(0, 4'b0000, 1, 2, T_REL);
    add(0, 4'b0000, 1, 3, T_REL);
    add(0, 4'b0010, 0, 0, 0);
    add(0, 4'b0010, 1, 1, T_PRESS);
    add(0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 1, T_REL);
    add(0, 4'b1111, 0, 0, 0);
    add(0, 4'b1111, 1, 2, T_PRESS);
    add(0, 4'b1111, 1, 3, T_PRESS);
    add(0, 4'b1111, 1, 0, T_PRESS);
    add(0, 4'b1111, 1, 1, T_PRESS);
    add(0, 4'b1111, 0, 0, 0);

    foreach (tbl[k]) begin
      btn = tbl[k].btn;
      if (tbl[k].rst) begin
        do_reset();
      end else begin
        tick_clk();
        expect_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].eb, tbl[k].et, 1'b0);
      end
    end

    // btn2 held 12 tick periods: PRESS, LONG, 4x REPEAT, RELEASE
    btn = '0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      btn[2] = (c < 48);
      tick_clk();
      collect();
    end
    xc = '{1, 12, 20, 28, 36, 44, 49};
    xt = '{T_PRESS, T_LONG, T_REP, T_REP, T_REP, T_REP, T_REL};
    cmp_events("hold2", 2'd2);

    // stalled consumer: stable output, drop, clear, set-wins-over-clear
    btn = '0;
    do_reset();
    evt_if.evt_ready = 1'b0;
    btn = 4'b0010; tick_clk(); expect_out("stall c0", 0, 0, 0, 0);
    tick_clk();                expect_out("stall c1", 1, 1, T_PRESS, 0);
    btn = 4'b0000; tick_clk(); expect_out("stall c2", 1, 1, T_PRESS, 0);
    btn = 4'b0010; tick_clk(); expect_out("stall c3", 1, 1, T_PRESS, 1);
    evt_if.ovf_clr = 1'b1; tick_clk(); expect_out("stall c4", 1, 1, T_PRESS, 0);
    btn = 4'b0000; tick_clk(); expect_out("stall c5", 1, 1, T_PRESS, 1);
    evt_if.ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
    tick_clk();                expect_out("stall c6", 1, 1, T_REL, 1);
    tick_clk();                expect_out("stall c7", 0, 0, 0, 1);

    // async reset while btn3 HELD with an event on the output
    btn = '0;
    do_reset();
    btn = 4'b1000;
    for (int c = 0; c < 13; c++) begin tick_clk(); collect(); end
    xc = '{1, 12};
    xt = '{T_PRESS, T_LONG};
    cmp_events("rst-pre", 2'd3);
    rst = 1'b1;
    #1;
    check("async rst valid", evt_if.evt_valid, 0);
    check("async rst btn",   evt_if.evt_btn,   0);
    check("async rst type",  evt_if.evt_type,  0);
    do_reset();
    for (int c = 0; c < 16; c++) begin tick_clk(); collect(); end
    xc = '{1, 12};
    xt = '{T_PRESS, T_LONG};
    cmp_events("rst-post", 2'd3);

    // release on the very tick that would have produced LONG
    btn = '0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      btn[0] = (c < 11);
      tick_clk();
      collect();
    end
    xc = '{1, 12};
    xt = '{T_PRESS, T_REL};
    cmp_events("fall-vs-long", 2'd0);

    // randomized traffic against the model
    btn = '0;
    do_reset();
    model_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 2000) do_reset();
      mask = '0;
      for (int i = 0; i < N_BTN; i++)
        mask = {mask[N_BTN-2:0], ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0};
      btn = btn ^ mask;
      evt_if.evt_ready = ($urandom_range(0, 9) < ((n < 1500) ? 7 : 3)) ? 1'b1 : 1'b0;
      evt_if.ovf_clr   = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      tick_clk();
      check("rnd valid", evt_if.evt_valid, m_valid);
      if (m_valid) begin
        check("rnd btn",  evt_if.evt_btn,  m_btn);
        check("rnd type", evt_if.evt_type, m_type);
      end
      check("rnd ovf", evt_if.evt_ovf, m_ovf);
    end
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
